// File: rtl/gas_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : gas_frame_receiver
//  Description : Recovers framed words (start, S data bits LSB-first,
//                optional even parity, stop) from the gas-engine shift
//                register's serial output. It raises a one-cycle valid pulse
//                for a good word and one-cycle pulses for parity, framing and
//                inter-bit timeout errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module gas_frame_receiver #(
    parameter int S         = 8,
    parameter int PARITY_EN = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [S-1:0] data_out,
    output logic         data_valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         busy
);

    localparam int c_CNT_W = $clog2(S + 1);
    localparam int c_T_W   = $clog2(TIMEOUT + 1);

    // Index of the last data bit. The timeout fires on the idle edge that
    // would take the counter to TIMEOUT.
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(S - 1);
    localparam logic [c_T_W-1:0]   c_T_LAST   = c_T_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [S-1:0]       r_acc;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_T_W-1:0]   r_tcnt;
    logic               r_par_bit;
    logic               w_par_ok;

    // Even parity: the received bit must equal the XOR of the data bits.
    assign w_par_ok = (PARITY_EN == 0) || (r_par_bit == ^r_acc);

    // Frame FSM. The pulse outputs default low every cycle, so each one is
    // high for exactly one cycle after the edge that raises it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_tcnt     <= '0;
            r_par_bit  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_tcnt <= '0;
                if (bit_valid && !bit_in) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= '0;
                    busy      <= 1'b1;
                end
            end else if (!bit_valid) begin
                if (r_tcnt == c_T_LAST) begin
                    // Transmitter stalled: drop the partial frame.
                    frame_err <= 1'b1;
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    r_tcnt    <= '0;
                    r_acc     <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end else begin
                r_tcnt <= '0;
                case (r_state)
                    ST_DATA: begin
                        // Shift right with the new bit at the MSB, so the
                        // first data bit ends up in bit 0.
                        r_acc     <= {bit_in, r_acc[S-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        r_par_bit <= bit_in;
                        r_state   <= ST_STOP;
                    end
                    default: begin
                        if (bit_in && w_par_ok) begin
                            data_out   <= r_acc;
                            data_valid <= 1'b1;
                        end
                        parity_err <= !w_par_ok;
                        frame_err  <= !bit_in;
                        r_state    <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gas_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gas_frame_receiver
//  Description : Scoreboard bench for gas_frame_receiver. One instance runs
//                with parity enabled and one without. Stimulus pushes the
//                expected outcome of each frame, and per-instance monitors
//                pop and compare those outcomes whenever a pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gas_frame_receiver;

    localparam int S  = 8;
    localparam int TO = 64;

    typedef struct packed {
        int unsigned cyc;
        logic        dv;
        logic        pe;
        logic        fe;
        logic [7:0]  data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       bv1 = 1'b0, bi1 = 1'b1, bv0 = 1'b0, bi0 = 1'b1;
    logic [7:0] do1, do0;
    logic       dv1, pe1, fe1, bz1;
    logic       dv0, pe0, fe0, bz0;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q1[$];
    exp_t        q0[$];
    logic [7:0]  good [2];
    logic        exp_busy [2];

    always #5 clk = ~clk;

    // Edge counter, used to timestamp expected pulses.
    always @(posedge clk) cyc <= cyc + 1;

    gas_frame_receiver #(.S(S), .PARITY_EN(1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .bit_in(bi1), .bit_valid(bv1),
        .data_out(do1), .data_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .busy(bz1)
    );

    gas_frame_receiver #(.S(S), .PARITY_EN(0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .bit_in(bi0), .bit_valid(bv0),
        .data_out(do0), .data_valid(dv0), .parity_err(pe0),
        .frame_err(fe0), .busy(bz0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int u, input exp_t e);
        if (u == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    // Per-cycle monitor: busy and held data every cycle, plus outcome pops.
    task automatic mon(input int u, input logic dv, input logic pe, input logic fe,
                       input logic bz, input logic [7:0] d);
        exp_t e;
        logic have;
        check($sformatf("busy%0d", u), {31'd0, bz}, {31'd0, exp_busy[u]});
        check($sformatf("data_out%0d", u), {24'd0, d}, {24'd0, good[u]});
        if (dv | pe | fe) begin
            have = 1'b0;
            if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse%0d actual dv/pe/fe=%b%b%b required none (cycle %0d)",
                         u, dv, pe, fe, cyc);
            end else begin
                check($sformatf("pulse_cycle%0d", u), cyc, e.cyc);
                check($sformatf("pulse_kind%0d", u), {29'd0, dv, pe, fe}, {29'd0, e.dv, e.pe, e.fe});
                check($sformatf("pulse_data%0d", u), {24'd0, d}, {24'd0, e.data});
            end
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) mon(1, dv1, pe1, fe1, bz1, do1);
    always @(negedge clk) mon(0, dv0, pe0, fe0, bz0, do0);

    // Drive one clock of input to unit u, then move to just after the edge.
    task automatic tick(input int u, input logic v, input logic b);
        if (u == 1) begin bv1 = v; bi1 = b; end
        else        begin bv0 = v; bi0 = b; end
        @(posedge clk);
        #1;
        bv1 = 1'b0; bi1 = 1'b1;
        bv0 = 1'b0; bi0 = 1'b1;
    endtask

    // Send one frame; the outcome follows from the frame rules directly.
    task automatic send_frame(input int u, input logic [7:0] data, input logic pflip,
                              input logic stop, input int maxgap);
        logic perr;
        logic [7:0] dd;
        exp_t e;
        dd = data;
        repeat ($urandom_range(0, maxgap)) tick(u, 1'b0, 1'b1);
        tick(u, 1'b1, 1'b0);
        exp_busy[u] = 1'b1;
        for (int i = 0; i < S; i++) begin
            repeat ($urandom_range(0, maxgap)) tick(u, 1'b0, 1'b1);
            tick(u, 1'b1, dd[i]);
        end
        if (u == 1) begin
            repeat ($urandom_range(0, maxgap)) tick(u, 1'b0, 1'b1);
            tick(u, 1'b1, (^dd) ^ pflip);
        end
        repeat ($urandom_range(0, maxgap)) tick(u, 1'b0, 1'b1);
        tick(u, 1'b1, stop);
        exp_busy[u] = 1'b0;
        perr = (u == 1) && pflip;
        if (stop && !perr) begin
            good[u] = dd;
            e = '{cyc: cyc, dv: 1'b1, pe: 1'b0, fe: 1'b0, data: dd};
        end else begin
            e = '{cyc: cyc, dv: 1'b0, pe: perr, fe: !stop, data: good[u]};
        end
        push(u, e);
    endtask

    // Start bit plus nbits further bits, then silence until the timeout.
    task automatic send_timeout(input int u, input int nbits);
        exp_t e;
        tick(u, 1'b1, 1'b0);
        exp_busy[u] = 1'b1;
        for (int i = 0; i < nbits; i++) tick(u, 1'b1, 1'($urandom_range(0, 1)));
        repeat (TO) tick(u, 1'b0, 1'b1);
        exp_busy[u] = 1'b0;
        e = '{cyc: cyc, dv: 1'b0, pe: 1'b0, fe: 1'b1, data: good[u]};
        push(u, e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        good[0] = 8'h00; good[1] = 8'h00;
        exp_busy[0] = 1'b0; exp_busy[1] = 1'b0;
    endtask

    initial begin
        int u;
        good[0] = 8'h00; good[1] = 8'h00;
        exp_busy[0] = 1'b0; exp_busy[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1, 1'b0, 1'b1);

        // Parity error with nothing received yet, then a good 0xA5.
        send_frame(1, 8'hA5, 1'b1, 1'b1, 0);
        send_frame(1, 8'hA5, 1'b0, 1'b1, 0);
        tick(1, 1'b0, 1'b1);
        // Bad stop bit, then a good frame.
        send_frame(1, 8'h3C, 1'b0, 1'b0, 0);
        send_frame(1, 8'h5A, 1'b0, 1'b1, 0);
        // Stop bit and parity both wrong.
        send_frame(1, 8'h77, 1'b1, 1'b0, 0);
        // Timeout after three data bits.
        send_timeout(1, 3);
        tick(1, 1'b0, 1'b1);
        // Back-to-back frames without parity.
        send_frame(0, 8'h01, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFE, 1'b0, 1'b1, 0);
        tick(0, 1'b0, 1'b1);
        // Reset after the fifth data bit, then a clean frame.
        tick(1, 1'b1, 1'b0);
        exp_busy[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick(1, 1'b1, 1'b1);
        do_reset();
        send_frame(1, 8'hA5, 1'b0, 1'b1, 0);

        // Randomized mix of frames, errors, ignored idle bits and timeouts.
        for (int n = 0; n < 60; n++) begin
            u = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick(u, 1'b1, 1'b1);
            if ($urandom_range(0, 9) == 0)
                send_timeout(u, int'($urandom_range(0, (u == 1) ? S + 1 : S)));
            else
                send_frame(u, 8'($urandom), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)));
        end

        repeat (4) tick(0, 1'b0, 1'b1);
        check("pending1", q1.size(), 0);
        check("pending0", q0.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
